alu_control_fsm: RTL and testbench
==================================

// Module: alu_control_fsm
// PURPOSE
//  Multicycle MIPS main controller and ALU-op issuer: drives the 4-bit ALU select, operand muxes and datapath enables.
//  Samples opcode/funct from the instruction register and sequences FETCH..WRITEBACK. Uses the ALU zero flag for beq.
//  Sits between the instruction register and the datapath built around alu32bit; holds in memory states until mem_ready.
// PARAMETERS
//  SUPPORT_ADDI  1  1: addi (opcode 001000) executes; 0: addi is treated as illegal
//  SUPPORT_JUMP  1  1: j (opcode 000010) executes; 0: j is treated as illegal
// PORTS
//  clk          in   1  single system clock, rising edge
//  rst_n        in   1  asynchronous reset, active low
//  opcode       in   6  instr[31:26]; sampled in DECODE only
//  funct        in   6  instr[5:0]; sampled in DECODE only
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory done this cycle (FETCH, MEMRD, MEMWR)
//  alu_select   out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
//  alu_src_a    out  1  0 = PC, 1 = reg A
//  alu_src_b    out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  pc_source    out  2  00 = ALU out, 01 = ALUOut reg, 10 = jump target
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load qualified by zero (beq taken)
//  i_or_d       out  1  0 = instruction address, 1 = data address
//  mem_read / mem_write / ir_write / reg_write  out  1 each  datapath enables
//  reg_dst      out  1  0 = rt, 1 = rd
//  mem_to_reg   out  1  0 = ALUOut, 1 = MDR
//  illegal      out  1  one-cycle pulse: unsupported opcode/funct decoded
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  - rst_n low: state <= RST(4'hF) asynchronously. In RST all enables, illegal, selects = 0. Next edge -> FETCH.
//  - Outputs are Moore (decoded from registered state), except pc_write_cond and illegal, which are gated as below.
//  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, add.
//    ir_write and pc_write = mem_ready. Stays until mem_ready=1, then -> DECODE.
//  - DECODE(1): alu_src_a=0, alu_src_b=11, add (branch target to ALUOut). Registers opcode/funct. Next state:
//      100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX;
//      otherwise (or disabled by parameter) -> FETCH with illegal=1 for that DECODE cycle.
//  - MEMADR(2): src_a=1, src_b=10, add. Next is MEMRD for lw, MEMWR for sw.
//  - MEMRD(3): mem_read=1, i_or_d=1. Holds until mem_ready, then -> MEMWB.
//  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - MEMWR(5): mem_write=1, i_or_d=1. Holds until mem_ready, then -> FETCH. mem_write stays high while waiting.
//  - EXEC(6): src_a=1, src_b=00. alu_select from registered funct:
//    20->0010, 22->0110, 24->0000, 25->0001, 2A->0111.
//    Other funct: illegal=1, -> FETCH with no writeback. Legal funct -> ALUWB.
//  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - BRANCH(8): src_a=1, src_b=00, sub, pc_source=01, pc_write_cond=zero (combinational from zero) -> FETCH.
//  - JUMP(9): pc_source=10, pc_write=1 -> FETCH.
//  - ADDIEX(10): src_a=1, src_b=10, add -> ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - Unused encodings (12-14): go to FETCH; all outputs 0.
//  - opcode/funct changes outside DECODE have no effect. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - rst_n asserted in any state, including a memory wait: outputs go to RST values within the same cycle. No write completes.
//  - Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
// STRUCTURE
//  - Package mips_ctrl_pkg: ALU select codes, opcode/funct constants, state enum (4-bit encodings above).
//  - Sub-module alu_decoder: combinational (alu_op[1:0], funct) -> alu_select, illegal_funct. Shared with a future pipelined control.
// TESTING
//  1. Reset for 3 cycles with opcode=100011, then release, mem_ready=1
//     -> state_dbg 15,0,1,2,3,4,0. reg_write=1 only in state 4. No enable is high during reset.
//  2. R-type funct=2A -> alu_select=0111 in EXEC, then reg_write=1, reg_dst=1.
//     funct=27 -> illegal pulse in EXEC, no reg_write, back to FETCH.
//  3. beq, zero=1 in BRANCH -> pc_write_cond=1, alu_select=0110, pc_source=01.
//     Same with zero=0 -> pc_write_cond=0.
//  4. sw with mem_ready low for 4 cycles in MEMWR -> mem_write held 4+1 cycles, i_or_d=1. Exit on the ready cycle.
//  5. rst_n pulled low mid-MEMRD -> state 15 immediately, mem_read=0. After release, restart at FETCH.
//  6. SUPPORT_ADDI=0 with opcode=001000 -> illegal pulse in DECODE, next state FETCH, no reg_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS controller:
// ALU select codes, opcode/funct values, FSM state encodings and the control word.
package mips_ctrl_pkg;

    localparam int unsigned ALU_SEL_W = 4;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned STATE_W   = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_RST    = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps an ALU operation class plus R-type funct to the 4-bit ALU select;
// flags funct codes the ALU cannot execute.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0]           alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 illegal_funct
);

    always_comb begin
        alu_select    = ALU_AND;
        illegal_funct = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_select = ALU_ADD;
            ALUOP_SUB: alu_select = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_select = ALU_ADD;
                    FN_SUB:  alu_select = ALU_SUB;
                    FN_AND:  alu_select = ALU_AND;
                    FN_OR:   alu_select = ALU_OR;
                    FN_SLT:  alu_select = ALU_SLT;
                    default: illegal_funct = 1'b1;
                endcase
            end
            default: alu_select = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_control_fsm.sv
// Multicycle MIPS main controller: sequences FETCH..WRITEBACK from the decoded
// opcode and drives ALU select, operand muxes and datapath enables.
module alu_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter bit SUPPORT_JUMP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_source,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state_dbg
);

    state_t               state_q;
    state_t               state_d;
    logic [OPCODE_W-1:0]  op_q;
    logic [FUNCT_W-1:0]   funct_q;
    ctrl_t                ctrl;
    logic [1:0]           alu_op;
    logic                 alu_en;
    logic [ALU_SEL_W-1:0] dec_select;
    logic                 dec_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction fields are captured once, on the DECODE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            funct_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q    <= opcode;
            funct_q <= funct;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct_q),
        .alu_select    (dec_select),
        .illegal_funct (dec_illegal)
    );

    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        alu_op  = ALUOP_ADD;
        alu_en  = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                alu_en         = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                state_d        = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                alu_en         = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J: begin
                        if (SUPPORT_JUMP) state_d = S_JUMP;
                        else              ctrl.illegal = 1'b1;
                    end
                    OP_ADDI: begin
                        if (SUPPORT_ADDI) state_d = S_ADDIEX;
                        else              ctrl.illegal = 1'b1;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                alu_en         = 1'b1;
                state_d        = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                state_d        = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                alu_op         = ALUOP_FUNCT;
                alu_en         = 1'b1;
                ctrl.illegal   = dec_illegal;
                state_d        = dec_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                alu_op             = ALUOP_SUB;
                alu_en             = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.pc_write_cond = zero;
            end
            S_JUMP: begin
                ctrl.pc_source = 2'b10;
                ctrl.pc_write  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                alu_en         = 1'b1;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            default:  state_d = S_FETCH;
        endcase
    end

    assign alu_select    = alu_en ? dec_select : ALU_AND;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign illegal       = ctrl.illegal;
    assign state_dbg     = STATE_W'(state_q);

endmodule

// File: tb/tb_alu_control_fsm.sv
// Randomized instruction-level bench for alu_control_fsm: each instruction is
// expanded into its expected per-cycle control trace and compared cycle by cycle.
module tb_alu_control_fsm;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    typedef struct packed {
        logic [3:0] st;
        logic       illegal;
        logic [3:0] alu;
        logic [1:0] pc_source;
        logic [1:0] src_b;
        logic       src_a;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       i_or_d;
        logic       reg_write;
        logic       pc_write_cond;
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_ready;
        logic       zero;
        logic [5:0] opcode;
        logic [5:0] funct;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b100011;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic [3:0] alu_select, state_dbg;
    logic [1:0] alu_src_b, pc_source;
    logic alu_src_a, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic ir_write, reg_write, reg_dst, mem_to_reg, illegal;

    logic [3:0] m_alu_select, m_state_dbg;
    logic [1:0] m_alu_src_b, m_pc_source;
    logic m_alu_src_a, m_pc_write, m_pc_write_cond, m_i_or_d, m_mem_read, m_mem_write;
    logic m_ir_write, m_reg_write, m_reg_dst, m_mem_to_reg, m_illegal;

    int   n_checks = 0;
    int   n_fail = 0;
    cyc_t q[$];

    always #5 clk = ~clk;

    alu_control_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_select(alu_select), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    // Reduced configuration: addi and j are not supported
    alu_control_fsm #(.SUPPORT_ADDI(1'b0), .SUPPORT_JUMP(1'b0)) u_dut_min (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_select(m_alu_select), .alu_src_a(m_alu_src_a),
        .alu_src_b(m_alu_src_b), .pc_source(m_pc_source), .pc_write(m_pc_write),
        .pc_write_cond(m_pc_write_cond), .i_or_d(m_i_or_d), .mem_read(m_mem_read),
        .mem_write(m_mem_write), .ir_write(m_ir_write), .reg_write(m_reg_write),
        .reg_dst(m_reg_dst), .mem_to_reg(m_mem_to_reg), .illegal(m_illegal),
        .state_dbg(m_state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] exp_vec(input cyc_t c);
        return {c.illegal, c.alu, c.pc_source, c.src_b, c.src_a, c.mem_to_reg, c.reg_dst,
                c.i_or_d, c.reg_write, c.pc_write_cond, c.pc_write, c.ir_write,
                c.mem_write, c.mem_read};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {illegal, alu_select, pc_source, alu_src_b, alu_src_a, mem_to_reg, reg_dst,
                i_or_d, reg_write, pc_write_cond, pc_write, ir_write, mem_write, mem_read};
    endfunction

    // {legal, alu select} for an R-type funct
    function automatic logic [4:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return {1'b1, 4'b0010};
            6'h22:   return {1'b1, 4'b0110};
            6'h24:   return {1'b1, 4'b0000};
            6'h25:   return {1'b1, 4'b0001};
            6'h2A:   return {1'b1, 4'b0111};
            default: return {1'b0, 4'b0000};
        endcase
    endfunction

    function automatic logic [5:0] ill_op();
        logic [5:0] o;
        do o = 6'($urandom);
        while (o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
        return o;
    endfunction

    // One cycle with all outputs idle and don't-care inputs randomized
    function automatic cyc_t base(input logic [3:0] st);
        cyc_t c = '0;
        c.st        = st;
        c.mem_ready = 1'($urandom);
        c.zero      = 1'($urandom);
        c.opcode    = 6'($urandom);
        c.funct     = 6'($urandom);
        return c;
    endfunction

    // Expand one instruction into its expected cycle trace
    task automatic build(input int kind, input logic [5:0] fn, input int fw, input int mw);
        cyc_t c;
        logic [5:0] op;
        logic [4:0] fa;
        case (kind)
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_R:     op = 6'b000000;
            K_BEQ:   op = 6'b000100;
            K_J:     op = 6'b000010;
            K_ADDI:  op = 6'b001000;
            default: op = ill_op();
        endcase
        for (int w = 0; w <= fw; w++) begin
            c = base(4'd0);
            c.mem_read = 1'b1; c.src_b = 2'b01; c.alu = 4'b0010;
            c.mem_ready = (w == fw); c.ir_write = c.mem_ready; c.pc_write = c.mem_ready;
            q.push_back(c);
        end
        c = base(4'd1);
        c.src_b = 2'b11; c.alu = 4'b0010; c.opcode = op; c.funct = fn;
        c.illegal = (kind == K_ILL);
        q.push_back(c);
        case (kind)
            K_LW, K_SW: begin
                c = base(4'd2); c.src_a = 1'b1; c.src_b = 2'b10; c.alu = 4'b0010;
                q.push_back(c);
                for (int w = 0; w <= mw; w++) begin
                    c = base((kind == K_LW) ? 4'd3 : 4'd5);
                    c.i_or_d = 1'b1; c.mem_ready = (w == mw);
                    if (kind == K_LW) c.mem_read = 1'b1;
                    else              c.mem_write = 1'b1;
                    q.push_back(c);
                end
                if (kind == K_LW) begin
                    c = base(4'd4); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    q.push_back(c);
                end
            end
            K_R: begin
                fa = funct_alu(fn);
                c = base(4'd6); c.src_a = 1'b1; c.alu = fa[3:0]; c.illegal = ~fa[4];
                q.push_back(c);
                if (fa[4]) begin
                    c = base(4'd7); c.reg_write = 1'b1; c.reg_dst = 1'b1;
                    q.push_back(c);
                end
            end
            K_BEQ: begin
                c = base(4'd8); c.src_a = 1'b1; c.alu = 4'b0110; c.pc_source = 2'b01;
                c.pc_write_cond = c.zero;
                q.push_back(c);
            end
            K_J: begin
                c = base(4'd9); c.pc_source = 2'b10; c.pc_write = 1'b1;
                q.push_back(c);
            end
            K_ADDI: begin
                c = base(4'd10); c.src_a = 1'b1; c.src_b = 2'b10; c.alu = 4'b0010;
                q.push_back(c);
                c = base(4'd11); c.reg_write = 1'b1;
                q.push_back(c);
            end
            default: ;
        endcase
    endtask

    task automatic run_queue(input int stop_after);
        int n = 0;
        while (q.size() > 0 && (stop_after < 0 || n < stop_after)) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge clk);
            mem_ready = c.mem_ready; zero = c.zero; opcode = c.opcode; funct = c.funct;
            #1;
            check($sformatf("state(s%0d)", c.st), 32'(state_dbg), 32'(c.st));
            check($sformatf("ctrl(s%0d)", c.st), 32'(dut_vec()), 32'(exp_vec(c)));
            n++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] legal_fn [5];
        int k;
        logic [5:0] fn;
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Reset held with a lw opcode and ready memory: nothing may be enabled
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_state", 32'(state_dbg), 32'd15);
            check("rst_ctrl", 32'(dut_vec()), 32'd0);
        end
        check("rst_state_min", 32'(m_state_dbg), 32'd15);
        @(negedge clk); rst_n = 1'b1;

        build(K_LW, 6'h00, 0, 0);   run_queue(-1);
        build(K_R, 6'h2A, 0, 0);    run_queue(-1);
        build(K_R, 6'h27, 0, 0);    run_queue(-1);
        build(K_BEQ, 6'h00, 0, 0);
        q[q.size()-1].zero = 1'b1; q[q.size()-1].pc_write_cond = 1'b1;
        run_queue(-1);
        build(K_BEQ, 6'h00, 1, 0);
        q[q.size()-1].zero = 1'b0; q[q.size()-1].pc_write_cond = 1'b0;
        run_queue(-1);
        build(K_SW, 6'h00, 0, 4);   run_queue(-1);
        build(K_J, 6'h00, 2, 0);    run_queue(-1);
        build(K_ADDI, 6'h00, 0, 0); run_queue(-1);

        // Reset arriving during a memory-read wait
        build(K_LW, 6'h00, 0, 3);
        run_queue(4);
        q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("midrd_state", 32'(state_dbg), 32'd15);
        check("midrd_ctrl", 32'(dut_vec()), 32'd0);
        @(negedge clk); #1;
        check("midrd_hold", 32'(state_dbg), 32'd15);
        rst_n = 1'b1;
        build(K_SW, 6'h00, 0, 1);   run_queue(-1);

        // addi and j in the reduced configuration decode as illegal
        pulse_reset();
        @(negedge clk); mem_ready = 1'b1; opcode = 6'b001000; #1;
        check("min_fetch", 32'(m_state_dbg), 32'd0);
        @(negedge clk); #1;
        check("min_addi_state", 32'(m_state_dbg), 32'd1);
        check("min_addi_illegal", 32'(m_illegal), 32'd1);
        check("main_addi_legal", 32'(illegal), 32'd0);
        @(negedge clk); opcode = 6'b000010; #1;
        check("min_addi_back", 32'(m_state_dbg), 32'd0);
        check("min_addi_nowb", 32'(m_reg_write), 32'd0);
        @(negedge clk); #1;
        check("min_j_illegal", 32'(m_illegal), 32'd1);
        @(negedge clk); #1;
        check("min_j_back", 32'(m_state_dbg), 32'd0);
        check("min_j_nopc", 32'(m_pc_write & ~m_ir_write), 32'd0);

        // Randomized instruction stream
        pulse_reset();
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else                           fn = legal_fn[$urandom_range(0, 4)];
            build(k, fn, $urandom_range(0, 2), $urandom_range(0, 3));
            run_queue(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
